traffic_lights_cmd_deframer: RTL and testbench
==============================================

Name: traffic_lights_cmd_deframer

Overview:
Upstream command stage for traffic_lights. Receives a byte stream (e.g. from a UART/host bridge) and assembles 5-byte frames. Validates each frame and emits one-cycle commands on the cmd_type/cmd_valid/cmd_data interface that drives the traffic_lights core. Rejected frames raise an error pulse with a code and bump a saturating error counter.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MAX_CMD_TYPE, 5, highest legal cmd_type value; larger values are rejected.
TIMEOUT_CLK, 2000, maximum idle clocks allowed between bytes inside a frame; must be >= 1.

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous reset, active-high
byte_data_i  in  8  incoming byte
byte_valid_i  in  1  byte_data_i valid this cycle
byte_ready_o  out  1  deframer accepts a byte this cycle
cmd_type_o  out  3  command type to traffic_lights
cmd_valid_o  out  1  one-cycle command strobe
cmd_data_o  out  16  command payload
err_o  out  1  one-cycle frame error strobe
err_code_o  out  2  1=bad checksum, 2=bad type, 3=timeout; held until the next err_o
err_cnt_o  out  8  saturating count of rejected frames

Behaviour:
- Interface and reset: single clock clk_i; srst_i is synchronous and active-high.
- Reset values: byte_ready_o=0, cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0, err_o=0, err_code_o=0, err_cnt_o=0. FSM returns to WAIT_SYNC and the timeout counter clears.
- Reset mid-frame discards the partial frame; no error is reported.
- byte_ready_o is 1 in every cycle after the first post-reset cycle. A byte is accepted when byte_valid_i && byte_ready_o.
- Frame format: SYNC, TYPE, DATA_HI, DATA_LO, CHK. CHK = TYPE ^ DATA_HI ^ DATA_LO.
- FSM states and transitions:
  - WAIT_SYNC -> GET_TYPE on an accepted byte equal to SYNC_BYTE; any other byte is silently dropped.
  - GET_TYPE -> GET_HI -> GET_LO -> GET_CHK, each advancing on an accepted byte; each byte is stored.
  - GET_CHK: on an accepted byte, evaluate the frame and return to WAIT_SYNC.
  - A SYNC_BYTE value received inside a frame is ordinary data; there is no resynchronisation.
- Frame evaluation, in priority order:
  - Checksum mismatch -> err code 1.
  - Else TYPE > MAX_CMD_TYPE (all 8 bits compared) -> err code 2.
  - Else the frame is good.
- Good frame: cmd_valid_o=1 for exactly one cycle, the cycle after the CHK byte is accepted (latency 1).
  - cmd_type_o = TYPE[2:0]; cmd_data_o = {DATA_HI, DATA_LO}.
  - cmd_type_o and cmd_data_o hold their values until the next good frame.
- Error: err_o=1 for one cycle, with the same timing as cmd_valid_o. err_code_o updates on the same cycle. err_cnt_o increments and saturates at 255.
- Timeout:
  - In GET_TYPE through GET_CHK, the idle counter clears on each accepted byte and increments on each cycle without one.
  - When the counter reaches TIMEOUT_CLK, the partial frame is aborted: return to WAIT_SYNC, err_o with code 3 next cycle.
  - If a byte is accepted in the same cycle the counter would reach TIMEOUT_CLK, the byte wins and no timeout occurs.
  - The counter is inactive in WAIT_SYNC.
  - Counter width is $clog2(TIMEOUT_CLK+1).
- Back-to-back: a new SYNC may be accepted the cycle after CHK. Consecutive frames need 5 clocks minimum, so at most one cmd_valid_o per 5 clocks.
- cmd_valid_o and err_o are never high in the same cycle.

Decomposition:
- Package traffic_lights_pkg holds:
  - cmd_type enum: 0 ON, 1 OFF, 2 UNSTRUCTURED, 3 SET_GREEN_MS, 4 SET_RED_MS, 5 SET_YELLOW_MS.
  - Deframer FSM state enum.
  - Error code localparams (ERR_CHK=1, ERR_TYPE=2, ERR_TIMEOUT=3).
- No sub-module needed; the timeout counter stays inline.
- A traffic_lights_cmd_deframer instance sits ahead of the traffic_lights input registers in the top level.

Test Plan:
- Good frame: bytes A5 03 01 F4 F6 on consecutive cycles -> one cycle after F6: cmd_valid_o=1, cmd_type_o=3, cmd_data_o=16'h01F4. err_o stays 0.
- Bad checksum: A5 00 00 00 01 -> err_o pulse, err_code_o=1, err_cnt_o=1, no cmd_valid_o.
- Bad type: A5 07 00 00 07 -> err_code_o=2. Also A5 85 00 00 85 -> err_code_o=2 (upper bits checked).
- Timeout with TIMEOUT_CLK=4: A5 02, then 4 idle cycles -> err_code_o=3. Then a good frame A5 01 00 00 01 is decoded normally. Same case with the next byte arriving on the 4th idle cycle -> no timeout.
- Junk and back-to-back: 11 22 A5 00 00 00 00 A5 01 00 00 01 with no gaps -> two cmd_valid_o pulses 5 cycles apart (types 0 and 1); junk bytes ignored. Then 300 bad frames -> err_cnt_o saturates at 255.
- Reset mid-frame: srst_i for 1 cycle after A5 04 12 -> no cmd_valid_o or err_o; all outputs return to 0. A following good frame decodes correctly.

Source files
------------

// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic_lights command path: command encodings,
// deframer FSM states and frame error codes.
package traffic_lights_pkg;

    typedef enum logic [2:0] {
        CMD_ON            = 3'd0,
        CMD_OFF           = 3'd1,
        CMD_UNSTRUCTURED  = 3'd2,
        CMD_SET_GREEN_MS  = 3'd3,
        CMD_SET_RED_MS    = 3'd4,
        CMD_SET_YELLOW_MS = 3'd5
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_WAIT_SYNC = 3'd0,
        ST_GET_TYPE  = 3'd1,
        ST_GET_HI    = 3'd2,
        ST_GET_LO    = 3'd3,
        ST_GET_CHK   = 3'd4
    } dfr_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TYPE    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Frame checksum covers TYPE, DATA_HI and DATA_LO.
    function automatic logic [7:0] frame_chk(input logic [7:0] t,
                                             input logic [7:0] hi,
                                             input logic [7:0] lo);
        return t ^ hi ^ lo;
    endfunction

endpackage

// File: rtl/traffic_lights_cmd_deframer.sv
// Assembles SYNC/TYPE/HI/LO/CHK byte frames into one-cycle commands for the
// traffic_lights core; rejected or stalled frames raise a coded error pulse.
module traffic_lights_cmd_deframer
    import traffic_lights_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_CMD_TYPE = 5,
    parameter int         TIMEOUT_CLK  = 2000
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic [2:0]  cmd_type_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_data_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [7:0]  err_cnt_o
);

    localparam int              CW      = $clog2(TIMEOUT_CLK + 1);
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT_CLK - 1);
    localparam logic [7:0]      MAX_T   = 8'(MAX_CMD_TYPE);

    dfr_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    type_q, type_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    lo_q, lo_d;
    logic          ready_q;
    logic          cmd_valid_q, cmd_valid_d;
    cmd_type_e     cmd_type_q, cmd_type_d;
    logic [15:0]   cmd_data_q, cmd_data_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          accept;
    logic          err_raise;
    logic [1:0]    err_sel;

    assign accept = byte_valid_i & ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cmd_valid_d = 1'b0;
        cmd_type_d  = cmd_type_q;
        cmd_data_d  = cmd_data_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        err_cnt_d   = err_cnt_q;
        err_raise   = 1'b0;
        err_sel     = ERR_NONE;

        case (state_q)
            ST_WAIT_SYNC: begin
                if (accept && byte_data_i == SYNC_BYTE) begin
                    state_d = ST_GET_TYPE;
                end
            end
            ST_GET_TYPE: begin
                if (accept) begin
                    type_d  = byte_data_i;
                    state_d = ST_GET_HI;
                end
            end
            ST_GET_HI: begin
                if (accept) begin
                    hi_d    = byte_data_i;
                    state_d = ST_GET_LO;
                end
            end
            ST_GET_LO: begin
                if (accept) begin
                    lo_d    = byte_data_i;
                    state_d = ST_GET_CHK;
                end
            end
            ST_GET_CHK: begin
                if (accept) begin
                    state_d = ST_WAIT_SYNC;
                    if (byte_data_i != frame_chk(type_q, hi_q, lo_q)) begin
                        err_raise = 1'b1;
                        err_sel   = ERR_CHK;
                    end else if (type_q > MAX_T) begin
                        err_raise = 1'b1;
                        err_sel   = ERR_TYPE;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_type_d  = cmd_type_e'(type_q[2:0]);
                        cmd_data_d  = {hi_q, lo_q};
                    end
                end
            end
            default: state_d = ST_WAIT_SYNC;
        endcase

        // Idle timer only runs inside a frame; an accepted byte beats an expiry.
        if (state_q == ST_WAIT_SYNC || accept) begin
            cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
            cnt_d     = '0;
            state_d   = ST_WAIT_SYNC;
            err_raise = 1'b1;
            err_sel   = ERR_TIMEOUT;
        end else begin
            cnt_d = CW'(cnt_q + 1'b1);
        end

        if (err_raise) begin
            err_d      = 1'b1;
            err_code_d = err_sel;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_WAIT_SYNC;
            cnt_q       <= '0;
            type_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            ready_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_ON;
            cmd_data_q  <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            type_q      <= type_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            ready_q     <= 1'b1;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_data_q  <= cmd_data_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_type_o   = cmd_type_q;
    assign cmd_data_o   = cmd_data_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_traffic_lights_cmd_deframer.sv
// Directed bench for traffic_lights_cmd_deframer: expected commands/errors are
// queued as frames are driven and compared when the DUT strobes an output.
module tb_traffic_lights_cmd_deframer;

    logic        clk = 1'b0;
    logic        srst_i;
    logic [7:0]  byte_data_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [2:0]  cmd_type_o;
    logic        cmd_valid_o;
    logic [15:0] cmd_data_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [7:0]  err_cnt_o;

    traffic_lights_cmd_deframer #(
        .SYNC_BYTE   (8'hA5),
        .MAX_CMD_TYPE(5),
        .TIMEOUT_CLK (4)
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst_i),
        .byte_data_i (byte_data_i),
        .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o),
        .cmd_type_o  (cmd_type_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_data_o  (cmd_data_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic [2:0]  typ;
        logic [15:0] data;
        logic [1:0]  code;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cmd_cyc = 0;
    int   prev_cmd_cyc = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decision for a complete frame, straight from the frame rules.
    task automatic push_frame(input logic [7:0] t, input logic [7:0] hi,
                              input logic [7:0] lo, input logic [7:0] c);
        exp_t e;
        e.typ  = 3'd0;
        e.data = 16'd0;
        e.code = 2'd0;
        if (c != (t ^ hi ^ lo)) begin
            e.is_err = 1'b1; e.code = 2'd1;
        end else if (t > 8'd5) begin
            e.is_err = 1'b1; e.code = 2'd2;
        end else begin
            e.is_err = 1'b0; e.typ = t[2:0]; e.data = {hi, lo};
        end
        if (e.is_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic push_timeout();
        exp_t e;
        e.is_err = 1'b1; e.typ = 3'd0; e.data = 16'd0; e.code = 2'd3;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data_i  = b;
        byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] t, input logic [7:0] hi,
                              input logic [7:0] lo, input logic [7:0] c);
        push_frame(t, hi, lo, c);
        send_byte(8'hA5);
        send_byte(t);
        send_byte(hi);
        send_byte(lo);
        send_byte(c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},   {31'd0, byte_ready_o}, 32'd0);
        check({tag, "_cvalid"},  {31'd0, cmd_valid_o},  32'd0);
        check({tag, "_ctype"},   {29'd0, cmd_type_o},   32'd0);
        check({tag, "_cdata"},   {16'd0, cmd_data_o},   32'd0);
        check({tag, "_err"},     {31'd0, err_o},        32'd0);
        check({tag, "_ecode"},   {30'd0, err_code_o},   32'd0);
        check({tag, "_ecnt"},    {24'd0, err_cnt_o},    32'd0);
    endtask

    // Scoreboard side: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (cmd_valid_o && err_o) check("both_strobes", 32'd1, 32'd0);
        if (cmd_valid_o) begin
            prev_cmd_cyc = last_cmd_cyc;
            last_cmd_cyc = cyc;
        end
        if (cmd_valid_o || err_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, cmd_valid_o, err_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {30'd0, cmd_valid_o, err_o},
                      e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    check("cmd_type", {29'd0, cmd_type_o}, {29'd0, e.typ});
                    check("cmd_data", {16'd0, cmd_data_o}, {16'd0, e.data});
                end else begin
                    check("err_code", {30'd0, err_code_o}, {30'd0, e.code});
                end
                check("err_cnt", {24'd0, err_cnt_o}, {24'd0, e.cnt});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stream [12];
        srst_i       = 1'b1;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        idle(3);
        srst_i = 1'b0;
        // First cycle after reset: not yet ready, everything zero.
        check_all_zero("reset");
        idle(1);
        check("ready_after", {31'd0, byte_ready_o}, 32'd1);

        send_frame(8'h03, 8'h01, 8'hF4, 8'hF6);
        idle(2);
        check("hold_type", {29'd0, cmd_type_o}, 32'd3);
        check("hold_data", {16'd0, cmd_data_o}, 32'h01F4);

        send_frame(8'h00, 8'h00, 8'h00, 8'h01);
        idle(2);
        check("cnt_after_chk", {24'd0, err_cnt_o}, 32'd1);
        send_frame(8'h07, 8'h00, 8'h00, 8'h07);
        send_frame(8'h85, 8'h00, 8'h00, 8'h85);
        idle(2);
        check("hold_type_after_err", {29'd0, cmd_type_o}, 32'd3);

        // Timeout: four idle cycles after TYPE abort the frame.
        push_timeout();
        send_byte(8'hA5);
        send_byte(8'h02);
        idle(6);
        check("ecode_hold", {30'd0, err_code_o}, 32'd3);
        send_frame(8'h01, 8'h00, 8'h00, 8'h01);
        idle(2);

        // Byte lands on the 4th idle cycle: no timeout.
        push_frame(8'h02, 8'h00, 8'h00, 8'h02);
        send_byte(8'hA5);
        send_byte(8'h02);
        idle(3);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h02);
        idle(2);
        check("cnt_no_timeout", {24'd0, err_cnt_o}, 32'd4);

        // Junk then two back-to-back frames.
        stream = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'hA5, 8'h01, 8'h00, 8'h00, 8'h01};
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);
        push_frame(8'h01, 8'h00, 8'h00, 8'h01);
        for (int i = 0; i < 12; i++) send_byte(stream[i]);
        idle(2);
        check("b2b_spacing", last_cmd_cyc - prev_cmd_cyc, 32'd5);

        for (int i = 0; i < 300; i++) send_frame(8'h00, 8'h00, 8'h00, 8'h01);
        idle(2);
        check("cnt_saturated", {24'd0, err_cnt_o}, 32'd255);

        // Reset mid-frame: partial frame vanishes silently.
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h12);
        srst_i = 1'b1;
        idle(1);
        srst_i = 1'b0;
        exp_cnt = 8'd0;
        check_all_zero("midreset");
        idle(8);
        check("midreset_quiet", {31'd0, cmd_valid_o | err_o}, 32'd0);
        send_frame(8'h05, 8'hAB, 8'hCD, 8'h63);
        idle(4);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
